dmem_arbiter: RTL and testbench

- Two-port arbiter that shares one data Memory instance (byte-lane Memory, func3-sized accesses, one-cycle read latency) between the RV32I data port and a secondary master (DMA / debug loader).
- Sits between the masters and the dMemory bus.
- Round-robin fairness, optional bounded burst lock for port 1, registered grants, per-port read-valid strobes.

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for one data memory; grants registered, first grant 1 cycle after req from idle.
// Backpressure: a waiting master holds its request until granted; handover is 0 bubbles on fairness, 1 on owner drop.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [2:0]    p0_func3,
    input  logic          p0_write,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    input  logic [2:0]    p1_func3,
    input  logic          p1_write,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    input  logic          p1_lock,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_func3,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CntTop = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] beatCnt;
    logic          lastOwner;
    logic          ownerReq;

    // Masters tap mem_rdata directly; the arbiter only times the rvalid strobes.
    logic unusedRdata;
    assign unusedRdata = ^mem_rdata;

    always_comb begin
        ownerReq  = 1'b0;
        mem_addr  = '0;
        mem_func3 = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        case (state)
            OWN0: begin
                ownerReq = p0_req;
                if (p0_req) begin
                    mem_addr  = p0_addr;
                    mem_func3 = p0_func3;
                    mem_write = p0_write;
                    mem_wdata = p0_wdata;
                end
            end
            OWN1: begin
                ownerReq = p1_req;
                if (p1_req) begin
                    mem_addr  = p1_addr;
                    mem_func3 = p1_func3;
                    mem_write = p1_write;
                    mem_wdata = p1_wdata;
                end
            end
            default: ownerReq = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (p0_req && p1_req) nextState = lastOwner ? OWN0 : OWN1;
                else if (p0_req)      nextState = OWN0;
                else if (p1_req)      nextState = OWN1;
            end
            OWN0: begin
                if (!p0_req)     nextState = p1_req ? OWN1 : IDLE;
                else if (p1_req) nextState = OWN1;
            end
            OWN1: begin
                if (!p1_req)
                    nextState = p0_req ? OWN0 : IDLE;
                else if (p0_req && !(p1_lock && (beatCnt < CntTop)))
                    nextState = OWN0;
            end
            default: nextState = IDLE;
        endcase
    end

    // Grants mirror the registered state; reset abandons any beat in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            beatCnt   <= '0;
            lastOwner <= 1'b1;
        end else begin
            state     <= nextState;
            p0_gnt    <= (nextState == OWN0);
            p1_gnt    <= (nextState == OWN1);
            p0_rvalid <= (state == OWN0) && p0_req && !p0_write;
            p1_rvalid <= (state == OWN1) && p1_req && !p1_write;
            if (nextState != state)
                beatCnt <= '0;
            else if (ownerReq && (beatCnt != CntTop))
                beatCnt <= beatCnt + 1'b1;
            if (nextState == OWN0 && state != OWN0) lastOwner <= 1'b0;
            if (nextState == OWN1 && state != OWN1) lastOwner <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane memory model (1-cycle read latency).
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req, p0_write, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata;
    logic [2:0]  p0_func3;
    logic        p1_req, p1_write, p1_gnt, p1_rvalid, p1_lock;
    logic [31:0] p1_addr, p1_wdata;
    logic [2:0]  p1_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;
    logic        mem_write;

    int total = 0;
    int bad   = 0;

    logic [31:0] memArr [0:1023];

    logic [31:0] q0Addr [16];
    logic [31:0] q0Data [16];
    logic [31:0] q0Exp  [16];
    logic        q0Wr   [16];
    logic [31:0] q1Addr [16];
    logic [31:0] q1Data [16];
    logic [31:0] q1Exp  [16];
    logic        q1Wr   [16];
    int          n0, n1;
    logic        lock1;
    int          logOwner [64];
    int          logCyc   [64];
    int          nLog;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_func3(p0_func3), .p0_write(p0_write),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_func3(p1_func3), .p1_write(p1_write),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_lock(p1_lock),
        .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write) begin
            case (mem_func3[1:0])
                2'b00:   memArr[mem_addr[11:2]][mem_addr[1:0]*8 +: 8] <= mem_wdata[7:0];
                2'b01:   memArr[mem_addr[11:2]][mem_addr[1]*16 +: 16] <= mem_wdata[15:0];
                default: memArr[mem_addr[11:2]] <= mem_wdata;
            endcase
        end
        mem_rdata <= memArr[mem_addr[11:2]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0; p0_func3 = 3'd2;
        p1_req = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0; p1_func3 = 3'd2;
        p1_lock = 1'b0;
    endtask

    // Both masters present their queued beats, advancing only on req && gnt.
    task automatic run_traffic(input int budget);
        int i0, i1, cyc;
        logic b0, b1, rd0, rd1;
        logic [31:0] e0, e1;
        i0 = 0; i1 = 0; cyc = 0; nLog = 0;
        rd0 = 1'b0; rd1 = 1'b0; e0 = '0; e1 = '0;
        while ((i0 < n0 || i1 < n1) && cyc < budget) begin
            total++;
            if (p0_rvalid !== rd0 || p1_rvalid !== rd1) begin
                bad++;
                $display("FAIL traffic_rvalid cyc=%0d got=%b%b want=%b%b", cyc, p0_rvalid, p1_rvalid, rd0, rd1);
            end
            if (rd0) begin
                total++;
                if (mem_rdata !== e0) begin
                    bad++;
                    $display("FAIL traffic_rdata0 cyc=%0d got=%h want=%h", cyc, mem_rdata, e0);
                end
            end
            if (rd1) begin
                total++;
                if (mem_rdata !== e1) begin
                    bad++;
                    $display("FAIL traffic_rdata1 cyc=%0d got=%h want=%h", cyc, mem_rdata, e1);
                end
            end
            p0_req = (i0 < n0);
            if (i0 < n0) begin
                p0_addr = q0Addr[i0]; p0_write = q0Wr[i0]; p0_wdata = q0Data[i0]; p0_func3 = 3'd2;
            end
            p1_req = (i1 < n1);
            if (i1 < n1) begin
                p1_addr = q1Addr[i1]; p1_write = q1Wr[i1]; p1_wdata = q1Data[i1]; p1_func3 = 3'd2;
            end
            p1_lock = lock1 && (i1 < n1);
            #1;
            total++;
            if (p0_gnt && p1_gnt) begin
                bad++;
                $display("FAIL traffic_both_gnt cyc=%0d got=11 want=not both", cyc);
            end
            b0 = p0_req && p0_gnt;
            b1 = p1_req && p1_gnt;
            if ((b0 || b1) && nLog < 64) begin
                logOwner[nLog] = b0 ? 0 : 1;
                logCyc[nLog]   = cyc;
                nLog++;
            end
            rd0 = b0 && !p0_write;
            rd1 = b1 && !p1_write;
            if (b0) e0 = q0Exp[i0];
            if (b1) e1 = q1Exp[i1];
            tick();
            if (b0) i0++;
            if (b1) i1++;
            cyc++;
        end
        total++;
        if (i0 < n0 || i1 < n1) begin
            bad++;
            $display("FAIL traffic_timeout got=%0d/%0d want=%0d/%0d", i0, i1, n0, n1);
        end
        total++;
        if (p0_rvalid !== rd0 || p1_rvalid !== rd1) begin
            bad++;
            $display("FAIL traffic_rvalid_tail got=%b%b want=%b%b", p0_rvalid, p1_rvalid, rd0, rd1);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        p0_req = 1'b1; p0_addr = 32'h0; p1_req = 1'b1; p1_addr = 32'h4;
        repeat (3) tick();
        total++;
        if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_gnt got=%b%b want=00", p0_gnt, p1_gnt);
        end
        total++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_rvalid got=%b%b want=00", p0_rvalid, p1_rvalid);
        end
        total++;
        if (mem_write !== 1'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL reset_mem got=%b/%h want=0/0", mem_write, mem_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if (p0_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_release_early got=%b want=0", p0_gnt);
        end
        tick();
        total++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_first_tie got=%b%b want=10", p0_gnt, p1_gnt);
        end
        idle_inputs();
        tick();
        total++;
        if (p0_rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_no_beat_rvalid got=%b want=0", p0_rvalid);
        end
        tick();
    endtask

    task automatic test_burst_lock();
        int expO [12];
        expO = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        n1 = 10; n0 = 2; lock1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q1Addr[i] = 32'h100 + 32'(4 * i);
            q1Data[i] = 32'hC000_0000 + 32'(i);
            q1Wr[i]   = 1'b1;
            q1Exp[i]  = '0;
        end
        q0Addr[0] = 32'h100; q0Exp[0] = 32'hC000_0000; q0Wr[0] = 1'b0; q0Data[0] = '0;
        q0Addr[1] = 32'h11C; q0Exp[1] = 32'hC000_0007; q0Wr[1] = 1'b0; q0Data[1] = '0;
        run_traffic(40);
        total++;
        if (nLog != 12) begin
            bad++; $display("FAIL burst_beats got=%0d want=12", nLog);
        end
        for (int k = 0; k < 12 && k < nLog; k++) begin
            total++;
            if (logOwner[k] != expO[k] || logCyc[k] != k + 1) begin
                bad++;
                $display("FAIL burst_seq beat=%0d got=p%0d@%0d want=p%0d@%0d", k, logOwner[k], logCyc[k], expO[k], k + 1);
            end
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (memArr[10'h40 + 10'(i)] !== 32'hC000_0000 + 32'(i)) begin
                bad++;
                $display("FAIL burst_mem idx=%0d got=%h want=%h", i, memArr[10'h40 + 10'(i)], 32'hC000_0000 + 32'(i));
            end
        end
        lock1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single();
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 32'h10; p0_func3 = 3'd2; p0_wdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if (p0_gnt !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL single_idle got=%b/%b want=0/0", p0_gnt, mem_write);
        end
        tick();
        total++;
        if (p0_gnt !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_write got=%b/%b/%h/%h want=1/1/00000010/deadbeef", p0_gnt, mem_write, mem_addr, mem_wdata);
        end
        tick();
        p0_write = 1'b0;
        #1;
        total++;
        if (memArr[4] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_commit got=%h want=deadbeef", memArr[4]);
        end
        total++;
        if (p0_gnt !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL single_read_beat got=%b/%b/%h want=1/0/00000010", p0_gnt, mem_write, mem_addr);
        end
        tick();
        total++;
        if (p0_rvalid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_rvalid got=%b/%h want=1/deadbeef", p0_rvalid, mem_rdata);
        end
        idle_inputs();
        tick();
        total++;
        if (p0_rvalid !== 1'b0 || p1_gnt !== 1'b0 || p1_rvalid !== 1'b0) begin
            bad++; $display("FAIL single_quiet got=%b/%b/%b want=0/0/0", p0_rvalid, p1_gnt, p1_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n0 = 4; n1 = 4; lock1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q0Addr[i] = 32'h40 + 32'(4 * i); q0Data[i] = 32'hA000_0000 + 32'(i); q0Wr[i] = 1'b1; q0Exp[i] = '0;
            q1Addr[i] = 32'h80 + 32'(4 * i); q1Data[i] = 32'hB000_0000 + 32'(i); q1Wr[i] = 1'b1; q1Exp[i] = '0;
        end
        run_traffic(40);
        total++;
        if (nLog != 8) begin
            bad++; $display("FAIL contention_beats got=%0d want=8", nLog);
        end
        for (int k = 0; k < 8 && k < nLog; k++) begin
            total++;
            if (logOwner[k] != (k % 2) || logCyc[k] != k + 1) begin
                bad++;
                $display("FAIL contention_seq beat=%0d got=p%0d@%0d want=p%0d@%0d", k, logOwner[k], logCyc[k], k % 2, k + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (memArr[10'h10 + 10'(i)] !== 32'hA000_0000 + 32'(i) ||
                memArr[10'h20 + 10'(i)] !== 32'hB000_0000 + 32'(i)) begin
                bad++;
                $display("FAIL contention_mem idx=%0d got=%h/%h want=%h/%h", i, memArr[10'h10 + 10'(i)],
                         memArr[10'h20 + 10'(i)], 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
            end
        end
        tick(); tick();
    endtask

    task automatic test_owner_drop();
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'h40;
        tick();
        total++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL drop_last_beat got=%b%b want=10", p0_gnt, p1_gnt);
        end
        tick();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h84;
        #1;
        total++;
        if (mem_write !== 1'b0 || mem_addr !== 32'h0 || p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL drop_bubble got=%b/%h/%b%b want=0/00000000/10", mem_write, mem_addr, p0_gnt, p1_gnt);
        end
        total++;
        if (p0_rvalid !== 1'b1 || mem_rdata !== 32'hA000_0000) begin
            bad++; $display("FAIL drop_rvalid0 got=%b/%h want=1/a0000000", p0_rvalid, mem_rdata);
        end
        tick();
        total++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || p0_rvalid !== 1'b0 || mem_addr !== 32'h84) begin
            bad++; $display("FAIL drop_handover got=%b%b/%b/%h want=10/0/00000084", p1_gnt, p0_gnt, p0_rvalid, mem_addr);
        end
        tick();
        p1_req = 1'b0;
        #1;
        total++;
        if (p1_rvalid !== 1'b1 || mem_rdata !== 32'hB000_0001) begin
            bad++; $display("FAIL drop_rvalid1 got=%b/%h want=1/b0000001", p1_rvalid, mem_rdata);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid_burst();
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 32'h200; p0_wdata = 32'h1111_1111;
        tick(); tick();
        idle_inputs();
        tick(); tick();
        total++;
        if (memArr[10'h80] !== 32'h1111_1111) begin
            bad++; $display("FAIL midrst_setup got=%h want=11111111", memArr[10'h80]);
        end
        p1_req = 1'b1; p1_write = 1'b1; p1_lock = 1'b1; p1_addr = 32'h200; p1_wdata = 32'h5555_5555;
        tick();
        total++;
        if (p1_gnt !== 1'b1 || mem_write !== 1'b1) begin
            bad++; $display("FAIL midrst_beat got=%b/%b want=1/1", p1_gnt, mem_write);
        end
        @(negedge clock);
        reset = 1'b0;
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'h10;
        #1;
        total++;
        if (p1_gnt !== 1'b0 || p0_gnt !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL midrst_clear got=%b%b/%b want=00/0", p0_gnt, p1_gnt, mem_write);
        end
        tick();
        total++;
        if (memArr[10'h80] !== 32'h1111_1111) begin
            bad++; $display("FAIL midrst_word got=%h want=11111111", memArr[10'h80]);
        end
        reset = 1'b1;
        tick();
        total++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++; $display("FAIL midrst_tie got=%b%b want=10", p0_gnt, p1_gnt);
        end
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_burst_lock();
        test_single();
        test_contention();
        test_owner_drop();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
